// File: rtl/npu_done_mailbox_pkg.sv
// Shared types and helpers for the NPU done-flag mailbox.
// Width constants are derived from the instantiating module's parameters, not kept here.
package npu_done_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } mbx_state_e;

  // Picks the preferred byte when its lane is enabled, otherwise keeps the base byte.
  function automatic logic [7:0] lane_merge(input logic [7:0] base_b,
                                            input logic [7:0] pref_b,
                                            input logic       pref_en);
    logic [7:0] res;
    if (pref_en) begin
      res = pref_b;
    end else begin
      res = base_b;
    end
    return res;
  endfunction

endpackage

// File: rtl/npu_done_mailbox_if.sv
// Avalon-MM slave bundle for one mailbox port (host or NPU side).
interface npu_done_mailbox_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
) ();
  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/npu_done_mailbox_ram.sv
// Single-clock true dual-port byte-enable RAM with registered reads.
// A read on one port during a write on the other to the same word returns the old word.
module npu_done_ram_tdp
  import npu_done_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_we,
  input  logic                a_re,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [DATA_W-1:0]   a_wd,
  output logic [DATA_W-1:0]   a_rd,
  input  logic                b_we,
  input  logic                b_re,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [DATA_W-1:0]   b_wd,
  output logic [DATA_W-1:0]   b_rd,
  output logic                coll
);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              coll_s;
  logic              a_we_eff_s;
  logic [NB-1:0]     b_be_eff_s;
  logic [DATA_W-1:0] b_wd_eff_s;
  logic [DATA_W-1:0] a_q_r;
  logic [DATA_W-1:0] b_q_r;

  // Same-word dual write: port B carries the lane-merged word and port A stands down.
  always_comb begin
    coll_s     = a_we & b_we & (a_addr == b_addr);
    a_we_eff_s = a_we & ~coll_s;
    b_be_eff_s = b_be;
    b_wd_eff_s = b_wd;
    if (coll_s) begin
      b_be_eff_s = a_be | b_be;
      for (int i = 0; i < NB; i++) begin
        b_wd_eff_s[i*8 +: 8] = lane_merge(a_wd[i*8 +: 8], b_wd[i*8 +: 8], b_be[i]);
      end
    end else begin
      b_be_eff_s = b_be;
      b_wd_eff_s = b_wd;
    end
  end

  // Byte-lane writes for both ports.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (a_we_eff_s && a_be[i]) begin
        mem[a_addr][i*8 +: 8] <= a_wd[i*8 +: 8];
      end
      if (b_we && b_be_eff_s[i]) begin
        mem[b_addr][i*8 +: 8] <= b_wd_eff_s[i*8 +: 8];
      end
    end
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q_r <= '0;
      b_q_r <= '0;
    end else begin
      if (a_re) begin
        a_q_r <= mem[a_addr];
      end
      if (b_re) begin
        b_q_r <= mem[b_addr];
      end
    end
  end

  assign a_rd = a_q_r;
  assign b_rd = b_q_r;
  assign coll = coll_s;
endmodule

// File: rtl/npu_done_mailbox.sv
// Host/NPU done-flag mailbox: cleared on reset by a sweep, then dual-port RAM access
// with per-channel sticky done flags, an interrupt and a sticky collision flag.
module npu_done_mailbox
  import npu_done_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 512,
  parameter int NUM_CH = 16
) (
  input  logic               clk,
  input  logic               reset,
  npu_done_mailbox_if.slave  s1,
  npu_done_mailbox_if.slave  s2,
  output logic [NUM_CH-1:0]  pending,
  output logic               irq,
  output logic               collision,
  output logic               init_busy
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int NB     = DATA_W / 8;

  mbx_state_e        state_r;
  logic [ADDR_W-1:0] ptr_r;
  logic              wait_r;
  logic              init_busy_r;
  logic [NUM_CH-1:0] pending_r;
  logic              irq_r;
  logic              collision_r;
  logic              rv1_r;
  logic              rv2_r;

  logic              stall_s;
  logic              s1_acc_s, s1_wr_s, s1_rd_s;
  logic              s2_acc_s, s2_wr_s, s2_rd_s;
  logic              a_we_s;
  logic [ADDR_W-1:0] a_addr_s;
  logic [NB-1:0]     a_be_s;
  logic [DATA_W-1:0] a_wd_s;
  logic [DATA_W-1:0] a_rd_s, b_rd_s;
  logic              coll_s;
  logic              s2_nz_s;
  logic [NUM_CH-1:0] set_s, clr_s;

  // Reset itself also stalls, so nothing is accepted on the edge that resets the block.
  assign stall_s = wait_r | reset;

  // Sweep state machine; the last swept address hands over to RUN on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_INIT;
      ptr_r       <= '0;
      wait_r      <= 1'b1;
      init_busy_r <= 1'b1;
    end else begin
      case (state_r)
        ST_INIT: begin
          ptr_r <= ptr_r + ADDR_W'(1);
          if (ptr_r == ADDR_W'(DEPTH - 1)) begin
            state_r     <= ST_RUN;
            wait_r      <= 1'b0;
            init_busy_r <= 1'b0;
          end else begin
            state_r     <= ST_INIT;
            wait_r      <= 1'b1;
            init_busy_r <= 1'b1;
          end
        end
        ST_RUN: begin
          state_r     <= ST_RUN;
          wait_r      <= 1'b0;
          init_busy_r <= 1'b0;
        end
        default: begin
          state_r     <= ST_INIT;
          ptr_r       <= '0;
          wait_r      <= 1'b1;
          init_busy_r <= 1'b1;
        end
      endcase
    end
  end

  // Request acceptance; write wins over read on the same port. Port A sweeps during INIT.
  always_comb begin
    s1_acc_s = s1.chipselect & (s1.read | s1.write) & ~stall_s;
    s1_wr_s  = s1_acc_s & s1.write;
    s1_rd_s  = s1_acc_s & ~s1.write;
    s2_acc_s = s2.chipselect & (s2.read | s2.write) & ~stall_s;
    s2_wr_s  = s2_acc_s & s2.write;
    s2_rd_s  = s2_acc_s & ~s2.write;
    if (state_r == ST_INIT) begin
      a_we_s   = 1'b1;
      a_addr_s = ptr_r;
      a_be_s   = '1;
      a_wd_s   = '0;
    end else begin
      a_we_s   = s1_wr_s;
      a_addr_s = s1.address;
      a_be_s   = s1.byteenable;
      a_wd_s   = s1.writedata;
    end
  end

  npu_done_ram_tdp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .a_we   (a_we_s),
    .a_re   (s1_rd_s),
    .a_addr (a_addr_s),
    .a_be   (a_be_s),
    .a_wd   (a_wd_s),
    .a_rd   (a_rd_s),
    .b_we   (s2_wr_s),
    .b_re   (s2_rd_s),
    .b_addr (s2.address),
    .b_be   (s2.byteenable),
    .b_wd   (s2.writedata),
    .b_rd   (b_rd_s),
    .coll   (coll_s)
  );

  // Done-flag decode: an NPU write with a nonzero enabled byte sets, any host write clears.
  always_comb begin
    s2_nz_s = 1'b0;
    set_s   = '0;
    clr_s   = '0;
    for (int i = 0; i < NB; i++) begin
      s2_nz_s = s2_nz_s | (s2.byteenable[i] & (|s2.writedata[i*8 +: 8]));
    end
    for (int c = 0; c < NUM_CH; c++) begin
      set_s[c] = s2_wr_s & s2_nz_s & (s2.address == ADDR_W'(c));
      clr_s[c] = s1_wr_s & (s1.address == ADDR_W'(c));
    end
  end

  // Sticky flags, interrupt and read-valid pulses; a same-cycle set beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r   <= '0;
      irq_r       <= 1'b0;
      collision_r <= 1'b0;
      rv1_r       <= 1'b0;
      rv2_r       <= 1'b0;
    end else begin
      pending_r   <= (pending_r & ~clr_s) | set_s;
      irq_r       <= |pending_r;
      collision_r <= collision_r | coll_s;
      rv1_r       <= s1_rd_s;
      rv2_r       <= s2_rd_s;
    end
  end

  assign s1.readdata      = a_rd_s;
  assign s1.readdatavalid = rv1_r;
  assign s1.waitrequest   = stall_s;
  assign s2.readdata      = b_rd_s;
  assign s2.readdatavalid = rv2_r;
  assign s2.waitrequest   = stall_s;
  assign pending          = pending_r;
  assign irq              = irq_r;
  assign collision        = collision_r;
  assign init_busy        = init_busy_r;
endmodule

// File: tb/tb_npu_done_mailbox.sv
// Scoreboard bench for npu_done_mailbox: directed scenarios plus random dual-port traffic
// checked against a word-array model of the mailbox.
module tb_npu_done_mailbox;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 512;
  localparam int NUM_CH = 16;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int NB     = DATA_W / 8;

  typedef struct packed {
    logic              cs;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wd;
  } op_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NUM_CH-1:0] pending;
  logic irq, collision, init_busy;

  npu_done_mailbox_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) s1 ();
  npu_done_mailbox_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) s2 ();

  npu_done_mailbox #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
    .clk       (clk),
    .reset     (reset),
    .s1        (s1),
    .s2        (s2),
    .pending   (pending),
    .irq       (irq),
    .collision (collision),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int tests = 0;
  int fails = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  logic [DATA_W-1:0] mem_m [DEPTH];
  logic [NUM_CH-1:0] exp_pend = '0;
  logic exp_irq = 1'b0;
  logic exp_coll = 1'b0;
  bit mon_en = 1'b0;
  logic [DATA_W-1:0] last1 = '0;
  logic [DATA_W-1:0] last2 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic op_t rd_op(input int addr);
    op_t o = '0;
    o.cs = 1'b1; o.rd = 1'b1; o.addr = ADDR_W'(addr);
    return o;
  endfunction

  function automatic op_t wr_op(input int addr, input logic [NB-1:0] be, input logic [DATA_W-1:0] wd);
    op_t o = '0;
    o.cs = 1'b1; o.wr = 1'b1; o.addr = ADDR_W'(addr); o.be = be; o.wd = wd;
    return o;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    int k = $urandom_range(0, 3);
    o.cs   = ($urandom_range(0, 7) != 0);
    o.rd   = (k == 1 || k == 3);
    o.wr   = (k >= 2);
    o.addr = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, DEPTH - 1))
                                         : ADDR_W'($urandom_range(0, 23));
    o.be   = NB'($urandom_range(0, 3));
    o.wd   = ($urandom_range(0, 3) == 0) ? '0 : DATA_W'($urandom);
    return o;
  endfunction

  task automatic drive(input op_t a, input op_t b);
    s1.chipselect = a.cs; s1.read = a.rd; s1.write = a.wr;
    s1.address = a.addr; s1.byteenable = a.be; s1.writedata = a.wd;
    s2.chipselect = b.cs; s2.read = b.rd; s2.write = b.wr;
    s2.address = b.addr; s2.byteenable = b.be; s2.writedata = b.wd;
  endtask

  // One RUN-state bus cycle: reads queue the word as it stands now, writes land afterwards,
  // with the NPU port applied last so its enabled lanes win a same-word clash.
  task automatic step(input op_t a, input op_t b);
    bit aw, ar, bw, br, bnz;
    int ai, bi;
    logic [NUM_CH-1:0] np;
    drive(a, b);
    aw = a.cs && a.wr;
    ar = a.cs && a.rd && !a.wr;
    bw = b.cs && b.wr;
    br = b.cs && b.rd && !b.wr;
    ai = int'(a.addr);
    bi = int'(b.addr);
    if (ar) q1.push_back('{data: mem_m[ai], cyc: cyc_cnt + 1});
    if (br) q2.push_back('{data: mem_m[bi], cyc: cyc_cnt + 1});
    @(posedge clk); #1;
    np  = exp_pend;
    bnz = 1'b0;
    for (int i = 0; i < NB; i++) if (b.be[i] && b.wd[i*8 +: 8] != 8'h00) bnz = 1'b1;
    if (aw) begin
      for (int i = 0; i < NB; i++) if (a.be[i]) mem_m[ai][i*8 +: 8] = a.wd[i*8 +: 8];
      if (ai < NUM_CH) np[ai] = 1'b0;
    end
    if (bw) begin
      for (int i = 0; i < NB; i++) if (b.be[i]) mem_m[bi][i*8 +: 8] = b.wd[i*8 +: 8];
      if (bi < NUM_CH && bnz) np[bi] = 1'b1;
    end
    if (aw && bw && ai == bi) exp_coll = 1'b1;
    exp_irq  = |exp_pend;
    exp_pend = np;
    drive('0, '0);
    chk("pending", 32'(pending), 32'(exp_pend));
    chk("irq", 32'(irq), 32'(exp_irq));
    chk("collision", 32'(collision), 32'(exp_coll));
  endtask

  task automatic do_reset(input int ncyc);
    mon_en = 1'b0;
    reset = 1'b1;
    repeat (ncyc) @(posedge clk);
    #1;
    chk("rst_init_busy", 32'(init_busy), 32'd1);
    chk("rst_wait", {30'd0, s1.waitrequest, s2.waitrequest}, 32'd3);
    chk("rst_rdv", {30'd0, s1.readdatavalid, s2.readdatavalid}, 32'd0);
    chk("rst_rdata1", 32'(s1.readdata), 32'd0);
    chk("rst_rdata2", 32'(s2.readdata), 32'd0);
    chk("rst_flags", {13'd0, irq, collision, pending}, 32'd0);
    reset = 1'b0;
  endtask

  // Counts edges until init_busy drops; requests held during the sweep must be ignored.
  task automatic wait_sweep(input string name);
    int n = 0;
    bit bad = 1'b0;
    while (n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (!init_busy) break;
      if (!(s1.waitrequest && s2.waitrequest)) bad = 1'b1;
      if (pending != '0) bad = 1'b1;
    end
    drive('0, '0);
    chk(name, 32'(n), 32'(DEPTH));
    chk("sweep_stall", 32'(bad), 32'd0);
    chk("run_wait", {30'd0, s1.waitrequest, s2.waitrequest}, 32'd0);
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    exp_pend = '0;
    exp_irq  = 1'b0;
    exp_coll = 1'b0;
    mon_en   = 1'b1;
  endtask

  // Port monitors: pop the oldest expected read when it falls due, else readdata must hold.
  always @(negedge clk) begin
    if (!mon_en) begin
      last1 <= '0;
    end else if (q1.size() > 0 && q1[0].cyc <= cyc_cnt) begin
      e1 = q1.pop_front();
      chk("s1_rdv", 32'(s1.readdatavalid), 32'd1);
      chk("s1_rd_cycle", 32'(cyc_cnt), 32'(e1.cyc));
      chk("s1_rdata", 32'(s1.readdata), 32'(e1.data));
      last1 <= s1.readdata;
    end else if (s1.readdatavalid) begin
      chk("s1_rdv_spurious", 32'(s1.readdatavalid), 32'd0);
    end else begin
      chk("s1_rd_hold", 32'(s1.readdata), 32'(last1));
    end
  end

  always @(negedge clk) begin
    if (!mon_en) begin
      last2 <= '0;
    end else if (q2.size() > 0 && q2[0].cyc <= cyc_cnt) begin
      e2 = q2.pop_front();
      chk("s2_rdv", 32'(s2.readdatavalid), 32'd1);
      chk("s2_rd_cycle", 32'(cyc_cnt), 32'(e2.cyc));
      chk("s2_rdata", 32'(s2.readdata), 32'(e2.data));
      last2 <= s2.readdata;
    end else if (s2.readdatavalid) begin
      chk("s2_rdv_spurious", 32'(s2.readdatavalid), 32'd0);
    end else begin
      chk("s2_rd_hold", 32'(s2.readdata), 32'(last2));
    end
  end

  initial begin
    drive('0, '0);
    do_reset(3);
    drive(wr_op(5, 2'b11, 16'hFFFF), wr_op(6, 2'b11, 16'hFFFF));
    wait_sweep("init_len");

    step(rd_op(5), '0);
    step('0, '0);

    step('0, wr_op(3, 2'b11, 16'h0001));
    chk("pend3_set", 32'(pending[3]), 32'd1);
    chk("irq_lag", 32'(irq), 32'd0);
    step('0, '0);
    chk("irq_set", 32'(irq), 32'd1);
    step(wr_op(3, 2'b11, 16'h0000), '0);
    chk("pend3_clr", 32'(pending[3]), 32'd0);
    step('0, '0);
    chk("irq_clr", 32'(irq), 32'd0);
    step('0, wr_op(4, 2'b11, 16'h0000));
    chk("pend4_zero", 32'(pending[4]), 32'd0);
    step('0, wr_op(4, 2'b01, 16'hFF00));
    chk("pend4_masked", 32'(pending[4]), 32'd0);
    step('0, wr_op(16, 2'b11, 16'hFFFF));

    step(wr_op(7, 2'b11, 16'hFFFF), wr_op(7, 2'b11, 16'h0001));
    chk("race_pend7", 32'(pending[7]), 32'd1);
    step(rd_op(7), '0);
    step('0, '0);

    step(wr_op(40, 2'b11, 16'h1234), wr_op(40, 2'b01, 16'hABCD));
    chk("coll_flag", 32'(collision), 32'd1);
    step(rd_op(40), rd_op(40));
    step('0, '0);

    step(wr_op(50, 2'b11, 16'h0055), '0);
    step(rd_op(50), wr_op(50, 2'b11, 16'h0066));
    step(rd_op(50), '0);
    step(wr_op(51, 2'b10, 16'h7700), rd_op(51));
    step('0, rd_op(51));
    step('0, '0);

    repeat (600) step(rnd_op(), rnd_op());
    repeat (3) step('0, '0);
    chk("queues_drained", 32'(q1.size() + q2.size()), 32'd0);

    step(wr_op(100, 2'b11, 16'h00AA), '0);
    step(rd_op(100), '0);
    step('0, '0);
    do_reset(2);
    repeat (200) @(posedge clk);
    #1;
    do_reset(1);
    wait_sweep("resweep_len");
    step(rd_op(100), '0);
    step('0, '0);
    chk("queues_drained_end", 32'(q1.size() + q2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
